// File: rtl/song_pkg.sv
// rtl/song_pkg.sv - shared types and defaults for the song playback sequencer
package song_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        PAUSED  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 4;
    localparam logic [15:0] TICK_DIV_DEFAULT = 16'h11ad;

endpackage

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - sample-rate divider, one tick every TICK_DIV enabled cycles
module sample_tick_gen #(
    parameter int TICK_DIV = 4525
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Gated by en so a count parked at LAST while paused does not fire.
    assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/song_playback_ctrl.sv
// rtl/song_playback_ctrl.sv - play/pause/stop sequencer walking the song ROM
module song_playback_ctrl #(
    parameter int ADDR_W = song_pkg::ADDR_W,
    parameter int DATA_W = song_pkg::DATA_W,
    parameter int TICK_DIV = int'(song_pkg::TICK_DIV_DEFAULT),
    parameter logic [ADDR_W-1:0] END_ADDR = '1
) (
    input  logic              clk50Mghz,
    input  logic              rst,
    input  logic              play,
    input  logic              pause,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              playing,
    output logic              done
);

    import song_pkg::*;

    state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic valid_q, valid_d;
    logic tick_en, tick_clr, fetch_pending, at_end;

    assign tick_en  = (state_q == PLAYING);
    assign tick_clr = stop || (play && (state_q == IDLE || state_q == DONE));

    sample_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_i  (clk50Mghz),
        .rst_i  (rst),
        .en_i   (tick_en),
        .clr_i  (tick_clr),
        .tick_o (fetch_pending)
    );

    // The ROM word for addr_q has been stable for a full tick period, so it is captured on the tick edge.
    assign at_end = (addr_q == END_ADDR);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        if (stop) begin
            state_d  = IDLE;
            addr_d   = '0;
            sample_d = '0;
        end else begin
            if (fetch_pending) begin
                sample_d = rom_data;
                valid_d  = 1'b1;
                if (at_end) begin
                    addr_d = loop_en ? '0 : addr_q;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            case (state_q)
                IDLE, DONE: begin
                    if (play) begin
                        state_d = PLAYING;
                        addr_d  = '0;
                    end
                end
                PAUSED: begin
                    if (play) state_d = PLAYING;
                end
                PLAYING: begin
                    if (fetch_pending && at_end && !loop_en) state_d = DONE;
                    else if (pause)                          state_d = PAUSED;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk50Mghz or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign rom_addr     = addr_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign playing      = (state_q == PLAYING);
    assign done         = (state_q == DONE);

endmodule

// File: tb/tb_song_playback_ctrl.sv
// tb/tb_song_playback_ctrl.sv - self-checking bench for song_playback_ctrl
module tb_song_playback_ctrl;

    logic        clk50Mghz = 1'b0;
    logic        rst = 1'b1;
    logic        play = 1'b0, pause = 1'b0, stop = 1'b0, loop_en = 1'b0;
    logic [3:0]  rom_data = 4'd0;
    logic [16:0] rom_addr;
    logic [3:0]  sample;
    logic        sample_valid, playing, done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        play;
        logic [3:0]  sample;
        logic        valid;
        logic [16:0] addr;
        logic        playing;
        logic        done;
    } vec_t;

    vec_t tbl[45];
    vec_t exp_q[$];

    song_playback_ctrl #(
        .TICK_DIV (4),
        .END_ADDR (17'd5)
    ) dut (
        .clk50Mghz    (clk50Mghz),
        .rst          (rst),
        .play         (play),
        .pause        (pause),
        .stop         (stop),
        .loop_en      (loop_en),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .sample       (sample),
        .sample_valid (sample_valid),
        .playing      (playing),
        .done         (done)
    );

    always #5 clk50Mghz = ~clk50Mghz;

    always @(posedge clk50Mghz) rom_data <= rom_addr[3:0] + 4'd1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic p, input logic pa, input logic s);
        play = p; pause = pa; stop = s;
        @(posedge clk50Mghz);
        #1;
        play = 1'b0; pause = 1'b0; stop = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        for (int i = 0; i < max; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n = i + 1;
            if (sample_valid) break;
        end
        chk("valid_seen", 32'(sample_valid), 32'd1);
    endtask

    initial begin
        int n, vcnt;
        vec_t e;

        for (int k = 0; k < 45; k++) begin
            int c, nraw, ns;
            c = k + 1;
            nraw = (c >= 5) ? ((c - 5) / 4 + 1) : 0;
            ns = (nraw > 6) ? 6 : nraw;
            tbl[k].play    = (k == 0);
            tbl[k].sample  = 4'(ns);
            tbl[k].valid   = (c >= 5) && ((c - 5) % 4 == 0) && (nraw <= 6);
            tbl[k].addr    = (ns == 6) ? 17'd5 : 17'(ns);
            tbl[k].done    = (ns == 6);
            tbl[k].playing = (ns != 6);
        end

        #12;
        chk("rst_sample", 32'(sample), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_playing", 32'(playing), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk50Mghz); #1;
        rst = 1'b0;

        // Start, six samples, end without loop, 20 quiet cycles
        for (int k = 0; k < 45; k++) begin
            exp_q.push_back(tbl[k]);
            step(tbl[k].play, 1'b0, 1'b0);
            e = exp_q.pop_front();
            chk($sformatf("tbl%0d_sample", k), 32'(sample), 32'(e.sample));
            chk($sformatf("tbl%0d_valid", k), 32'(sample_valid), 32'(e.valid));
            chk($sformatf("tbl%0d_addr", k), 32'(rom_addr), 32'(e.addr));
            chk($sformatf("tbl%0d_playing", k), 32'(playing), 32'(e.playing));
            chk($sformatf("tbl%0d_done", k), 32'(done), 32'(e.done));
        end

        // Restart from DONE
        step(1'b1, 1'b0, 1'b0);
        chk("restart_done", 32'(done), 32'd0);
        wait_valid(20, n);
        chk("restart_latency", 32'(n), 32'd4);
        chk("restart_sample", 32'(sample), 32'd1);
        chk("restart_addr", 32'(rom_addr), 32'd1);

        // Looping
        loop_en = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        chk("stop_sample", 32'(sample), 32'd0);
        chk("stop_addr", 32'(rom_addr), 32'd0);
        chk("stop_playing", 32'(playing), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            int ea;
            ea = (j < 5) ? j + 1 : j - 5;
            wait_valid(8, n);
            chk($sformatf("loop%0d_sample", j), 32'(sample), 32'((j % 6) + 1));
            chk($sformatf("loop%0d_addr", j), 32'(rom_addr), 32'(ea));
            chk($sformatf("loop%0d_done", j), 32'(done), 32'd0);
        end

        // Pause two cycles after a sample, then resume
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        wait_valid(8, n);
        chk("pr_first_sample", 32'(sample), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("pr_paused", 32'(playing), 32'd0);
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (sample_valid) vcnt++;
        end
        chk("pr_no_valid", 32'(vcnt), 32'd0);
        chk("pr_held", 32'(sample), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        chk("pr_resume_q", 32'(sample_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("pr_resume_valid", 32'(sample_valid), 32'd1);
        chk("pr_resume_sample", 32'(sample), 32'd2);
        chk("pr_resume_addr", 32'(rom_addr), 32'd2);

        // stop + play together while PLAYING
        step(1'b1, 1'b0, 1'b1);
        chk("sp_playing", 32'(playing), 32'd0);
        chk("sp_sample", 32'(sample), 32'd0);
        chk("sp_addr", 32'(rom_addr), 32'd0);

        // pause on the tick cycle still yields one capture
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("pt_valid", 32'(sample_valid), 32'd1);
        chk("pt_sample", 32'(sample), 32'd1);
        chk("pt_paused", 32'(playing), 32'd0);
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (sample_valid) vcnt++;
        end
        chk("pt_single", 32'(vcnt), 32'd0);
        chk("pt_held", 32'(sample), 32'd1);
        chk("pt_done", 32'(done), 32'd0);

        // Async reset between tick and capture
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        wait_valid(8, n);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("ar_pre_sample", 32'(sample), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_sample", 32'(sample), 32'd0);
        chk("ar_addr", 32'(rom_addr), 32'd0);
        chk("ar_playing", 32'(playing), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        @(posedge clk50Mghz); #1;
        chk("ar_no_valid", 32'(sample_valid), 32'd0);
        rst = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (sample_valid || playing) vcnt++;
        end
        chk("ar_idle", 32'(vcnt), 32'd0);
        chk("ar_idle_addr", 32'(rom_addr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/song_playback_ctrl.md
Name: song_playback_ctrl

Overview:
Sequencer for the 4-bit song sample ROM. It takes play/pause/stop commands and generates the sample-rate tick internally from clk50Mghz. It walks the ROM address from 0 to END_ADDR, registers each ROM word as a sample with a one-cycle valid strobe, and either stops or loops at the end of the song. It sits between the user controls and the ROM/audio output.

Parameters:
ADDR_W, 17, ROM address width
DATA_W, 4, ROM/sample data width
TICK_DIV, 4525, clk50Mghz cycles per sample (16'h11ad, approx. 11.05 kHz)
END_ADDR, 17'h1FFFF, last ROM address of the song

Ports:
clk50Mghz  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
play  in  1  level-sampled each cycle: start from IDLE/DONE, resume from PAUSED
pause  in  1  level-sampled: pause while PLAYING
stop  in  1  level-sampled: abort to IDLE from any state
loop_en  in  1  sampled when the END_ADDR sample is captured
rom_addr  out  ADDR_W  ROM address, registered
rom_data  in  DATA_W  ROM word; valid one cycle after rom_addr changes (registered ROM)
sample  out  DATA_W  current audio sample, registered
sample_valid  out  1  one-cycle pulse when sample updates
playing  out  1  high in PLAYING
done  out  1  high in DONE

Behaviour:
- Reset (async, any state, including mid-fetch): state=IDLE, rom_addr=0, sample=0, sample_valid=0, playing=0, done=0, tick counter=0, fetch_pending=0.
- States: IDLE, PLAYING, PAUSED, DONE. playing and done are decoded from registered state.
- Command priority within one cycle: stop > play > pause.
  - stop in any state: next state IDLE, rom_addr=0, sample=0, tick counter=0, fetch_pending cleared.
  - play in IDLE or DONE: next state PLAYING, rom_addr=0, tick counter=0.
  - play in PAUSED: next state PLAYING; rom_addr and tick counter are preserved.
  - play in PLAYING: ignored.
  - pause in PLAYING: next state PAUSED. Ignored in other states.
- Tick counter: counts only in PLAYING and wraps TICK_DIV-1 -> 0. tick=1 on the cycle where count==TICK_DIV-1. It holds its value in PAUSED.
- Fetch: tick sets fetch_pending for one cycle.
- Capture: on the following cycle, sample <= rom_data, sample_valid=1 and rom_addr advances. Latency is tick -> sample_valid = 1 cycle.
- A capture already pending completes even if pause arrives on the tick cycle. stop cancels it.
- End of song: on the capture of the END_ADDR word:
  - loop_en=1: rom_addr wraps to 0 and the state stays PLAYING.
  - loop_en=0: the state goes to DONE, rom_addr holds END_ADDR, and no further sample_valid pulses occur.
- sample holds its last value in PAUSED and DONE, and is 0 in IDLE.
- Width rule: rom_addr increments modulo 2^ADDR_W. The END_ADDR comparison takes precedence over natural wrap.

Decomposition:
- Shared package song_pkg holds:
  - the state enum {IDLE, PLAYING, PAUSED, DONE}
  - ADDR_W and DATA_W
  - the default TICK_DIV (16'h11ad)
- One sub-module, sample_tick_gen: divider with inputs en and clr, output tick, parameter TICK_DIV.
- The address counter and FSM stay in song_playback_ctrl.

Test Plan:
(All with TICK_DIV=4, END_ADDR=5, ROM model rom[i]=i+1, 1-cycle read latency.)
1. Start: rst deasserted, play pulse at cycle 0 -> playing=1 from cycle 1. First tick at cycle 4, sample_valid at cycle 5 with sample=1 and rom_addr=1. Subsequent sample_valid pulses every 4 cycles.
2. End, no loop (loop_en=0): after the 6th sample_valid (sample=6) -> done=1, playing=0, rom_addr=5. No further sample_valid pulses for 20 cycles. A play pulse then restarts with first sample=1.
3. Loop (loop_en=1): the 7th sample_valid has sample=1, rom_addr sequence is 5 -> 0 -> 1, and done stays 0.
4. Pause/resume: pause 2 cycles after a sample_valid -> no valid pulses while paused, sample is held. play resumes, and the next sample_valid comes 2 cycles after resume (counter preserved) with the next address's data.
5. Simultaneous events: stop+play in the same cycle while PLAYING -> IDLE, sample=0, rom_addr=0. pause asserted on the tick cycle -> the pending capture still produces exactly one sample_valid, then PAUSED.
6. Async reset mid-fetch: rst asserted between tick and capture (not on a clock edge) -> all outputs 0 immediately with no sample_valid pulse. After release, the state is IDLE until play.
